// File: rtl/tree_dispatch_pkg.sv
// Shared definitions for the tree round-robin dispatcher.
//   - state_e        : holding-register FSM states
//   - DEF_*          : default parameter values
//   - rr_wrap_inc()  : increment an index modulo n
package tree_dispatch_pkg;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } state_e;

   localparam int unsigned DEF_DATA_W    = 16;
   localparam int unsigned DEF_NUM_CHILD = 5;
   localparam int unsigned DEF_CNT_W     = 16;

   // Next index after idx, wrapping n-1 -> 0.
   function automatic int unsigned rr_wrap_inc(input int unsigned idx, input int unsigned n);
      return (idx + 32'd1 >= n) ? 32'd0 : idx + 32'd1;
   endfunction

endpackage

// File: rtl/rr_next_enabled.sv
// Combinational round-robin selector.
// Finds the first enabled child scanning i_ptr, i_ptr+1, ... with wrap at NUM_CHILD.
//   i_ptr      : starting index (must be < NUM_CHILD)
//   i_child_en : per-child enable mask
//   o_sel      : selected child index (meaningful only when o_any_en)
//   o_any_en   : at least one child enabled
module rr_next_enabled #(
   parameter int unsigned NUM_CHILD = 5,
   parameter int unsigned IDX_W     = 3
) (
   input  logic [IDX_W-1:0]     i_ptr,
   input  logic [NUM_CHILD-1:0] i_child_en,
   output logic [IDX_W-1:0]     o_sel,
   output logic                 o_any_en
);

   logic [NUM_CHILD-1:0] w_rot;
   logic [IDX_W-1:0]     w_off;
   logic                 w_found;

   // (a + b) mod NUM_CHILD for a, b < NUM_CHILD; one extra bit avoids overflow.
   function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] a,
                                                  input logic [IDX_W-1:0] b);
      logic [IDX_W:0] s;
      s = {1'b0, a} + {1'b0, b};
      if (s >= (IDX_W+1)'(NUM_CHILD)) s = s - (IDX_W+1)'(NUM_CHILD);
      return s[IDX_W-1:0];
   endfunction

   always_comb begin
      w_rot   = '0;
      w_off   = '0;
      w_found = 1'b0;
      // Rotate so that bit 0 corresponds to i_ptr.
      for (int i = 0; i < int'(NUM_CHILD); i++) begin
         w_rot[i] = i_child_en[wrap_add(i_ptr, IDX_W'(i))];
      end
      // Lowest set bit of the rotated mask is the offset from i_ptr.
      for (int i = 0; i < int'(NUM_CHILD); i++) begin
         if (!w_found && w_rot[i]) begin
            w_off   = IDX_W'(i);
            w_found = 1'b1;
         end
      end
   end

   // Un-rotate back to an absolute child index.
   assign o_sel    = wrap_add(i_ptr, w_off);
   assign o_any_en = |i_child_en;

endmodule

// File: rtl/tree_rr_dispatcher.sv
// Round-robin dispatch stage: one parent valid/ready stream fanned out to
// NUM_CHILD children through a single holding register.
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid/in_ready   : parent handshake, in_data payload
//   child_en            : per-child enable mask (sampled at load only)
//   out_valid/out_ready : one-hot offer to the target child and its accept
//   out_data            : held word, shared by all children
//   busy                : holding register occupied
//   dispatch_cnt        : completed child handshakes, wraps
module tree_rr_dispatcher
   import tree_dispatch_pkg::*;
#(
   parameter int unsigned DATA_W    = DEF_DATA_W,
   parameter int unsigned NUM_CHILD = DEF_NUM_CHILD,
   parameter int unsigned CNT_W     = DEF_CNT_W
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [DATA_W-1:0]    in_data,
   input  logic [NUM_CHILD-1:0] child_en,
   output logic [NUM_CHILD-1:0] out_valid,
   input  logic [NUM_CHILD-1:0] out_ready,
   output logic [DATA_W-1:0]    out_data,
   output logic                 busy,
   output logic [CNT_W-1:0]     dispatch_cnt
);

   localparam int unsigned IDX_W = (NUM_CHILD > 1) ? $clog2(NUM_CHILD) : 1;

   state_e             r_state, r_state_d;
   logic [DATA_W-1:0]  r_hold, r_hold_d;
   logic [IDX_W-1:0]   r_tgt, r_tgt_d;
   logic [IDX_W-1:0]   r_ptr, r_ptr_d;
   logic [CNT_W-1:0]   r_cnt, r_cnt_d;

   logic               w_out_fire;
   logic               w_load;
   logic               w_any_en;
   logic [IDX_W-1:0]   w_ptr_inc;
   logic [IDX_W-1:0]   w_ptr_scan;
   logic [IDX_W-1:0]   w_sel;

   always_comb begin
      w_out_fire = 1'b0;
      if (r_state == ST_FULL) w_out_fire = out_ready[r_tgt];
   end

   assign w_ptr_inc  = IDX_W'(rr_wrap_inc(32'(r_tgt), NUM_CHILD));
   // A reload in the fire cycle must scan from the already-advanced pointer.
   assign w_ptr_scan = w_out_fire ? w_ptr_inc : r_ptr;

   rr_next_enabled #(
      .NUM_CHILD (NUM_CHILD),
      .IDX_W     (IDX_W)
   ) u_next (
      .i_ptr      (w_ptr_scan),
      .i_child_en (child_en),
      .o_sel      (w_sel),
      .o_any_en   (w_any_en)
   );

   // Gated by rst so the parent never sees ready during reset.
   assign in_ready = !rst && w_any_en && ((r_state == ST_EMPTY) || w_out_fire);
   assign w_load   = in_valid && in_ready;

   always_comb begin
      r_state_d = r_state;
      r_hold_d  = r_hold;
      r_tgt_d   = r_tgt;
      r_ptr_d   = r_ptr;
      r_cnt_d   = r_cnt;
      if (w_out_fire) begin
         r_ptr_d   = w_ptr_inc;
         r_cnt_d   = r_cnt + 1'b1;
         r_state_d = ST_EMPTY;
      end
      if (w_load) begin
         r_hold_d  = in_data;
         r_tgt_d   = w_sel;
         r_state_d = ST_FULL;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_EMPTY;
         r_hold  <= '0;
         r_tgt   <= '0;
         r_ptr   <= '0;
         r_cnt   <= '0;
      end else begin
         r_state <= r_state_d;
         r_hold  <= r_hold_d;
         r_tgt   <= r_tgt_d;
         r_ptr   <= r_ptr_d;
         r_cnt   <= r_cnt_d;
      end
   end

   always_comb begin
      out_valid = '0;
      if (r_state == ST_FULL) out_valid[r_tgt] = 1'b1;
   end

   assign out_data     = r_hold;
   assign busy         = (r_state == ST_FULL);
   assign dispatch_cnt = r_cnt;

endmodule

// File: tb/tb_tree_rr_dispatcher.sv
module tb_tree_rr_dispatcher;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_data;
   logic [4:0]  child_en;
   logic [4:0]  out_valid;
   logic [4:0]  out_ready;
   logic [15:0] out_data;
   logic        busy;
   logic [15:0] dispatch_cnt;

   int n_assert = 0;
   int n_fail   = 0;

   logic [4:0] exp_a [7];
   logic [4:0] exp_b [3];

   always #5 clk = ~clk;

   tree_rr_dispatcher dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_data      (in_data),
      .child_en     (child_en),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_data     (out_data),
      .busy         (busy),
      .dispatch_cnt (dispatch_cnt)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      rst      = 1'b1;
      in_valid = 1'b0;
      tick();
      rst      = 1'b0;
      #1;
   endtask

   initial begin
      exp_a = '{5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b00001, 5'b00010};
      exp_b = '{5'b00100, 5'b10000, 5'b00100};

      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      child_en  = 5'b11111;
      out_ready = 5'b11111;
      repeat (2) tick();
      #1;
      // Reset state: in_ready low during rst even with enables present.
      check("rst_in_ready", 32'(in_ready), 32'h0);
      check("rst_out_valid", 32'(out_valid), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_cnt", 32'(dispatch_cnt), 32'h0);
      check("rst_data", 32'(out_data), 32'h0);

      // Back-to-back rotation over all children.
      rst      = 1'b0;
      in_valid = 1'b1;
      in_data  = 16'h0010;
      #1;
      check("a_in_ready", 32'(in_ready), 32'h1);
      for (int k = 0; k < 7; k++) begin
         tick();
         check("a_out_valid", 32'(out_valid), 32'(exp_a[k]));
         check("a_out_data", 32'(out_data), 32'h10 + 32'(k));
         if (k < 6) in_data = 16'h0011 + 16'(k);
         else in_valid = 1'b0;
      end
      tick();
      check("a_busy", 32'(busy), 32'h0);
      check("a_cnt", 32'(dispatch_cnt), 32'd7);

      // Sparse mask 10100 from ptr 0: children 2, 4, 2.
      do_reset();
      child_en = 5'b10100;
      in_valid = 1'b1;
      in_data  = 16'h0020;
      for (int k = 0; k < 3; k++) begin
         tick();
         check("b_out_valid", 32'(out_valid), 32'(exp_b[k]));
         check("b_out_data", 32'(out_data), 32'h20 + 32'(k));
         if (k < 2) in_data = 16'h0021 + 16'(k);
         else in_valid = 1'b0;
      end
      tick();
      check("b_cnt", 32'(dispatch_cnt), 32'd3);

      // Backpressure on child 0 for 4 cycles.
      do_reset();
      child_en  = 5'b11111;
      out_ready = 5'b11110;
      in_valid  = 1'b1;
      in_data   = 16'hAAAA;
      tick();
      in_valid = 1'b0;
      for (int c = 0; c < 4; c++) begin
         #1;
         check("c_out_valid", 32'(out_valid), 32'h01);
         check("c_out_data", 32'(out_data), 32'hAAAA);
         check("c_in_ready", 32'(in_ready), 32'h0);
         check("c_busy", 32'(busy), 32'h1);
         tick();
      end
      out_ready = 5'b11111;
      #1;
      check("c_in_ready_fire", 32'(in_ready), 32'h1);
      tick();
      check("c_busy_after", 32'(busy), 32'h0);
      check("c_cnt", 32'(dispatch_cnt), 32'd1);

      // Target child 1 disabled while held: still delivered; next goes to child 3.
      out_ready = 5'b11101;
      in_valid  = 1'b1;
      in_data   = 16'h0B01;
      tick();
      in_valid = 1'b0;
      child_en = 5'b11001;
      #1;
      check("d_out_valid_hold", 32'(out_valid), 32'h02);
      check("d_in_ready", 32'(in_ready), 32'h0);
      tick();
      check("d_out_valid_stable", 32'(out_valid), 32'h02);
      out_ready = 5'b11111;
      in_valid  = 1'b1;
      in_data   = 16'h0B02;
      #1;
      check("d_in_ready_fire", 32'(in_ready), 32'h1);
      tick();
      check("d_out_valid_next", 32'(out_valid), 32'h08);
      check("d_out_data_next", 32'(out_data), 32'h0B02);
      check("d_cnt_mid", 32'(dispatch_cnt), 32'd2);
      in_valid = 1'b0;
      tick();
      check("d_cnt", 32'(dispatch_cnt), 32'd3);
      check("d_busy", 32'(busy), 32'h0);

      // No child enabled: nothing accepted until child 0 is enabled.
      child_en = 5'b00000;
      in_valid = 1'b1;
      in_data  = 16'h0C01;
      #1;
      check("e_in_ready", 32'(in_ready), 32'h0);
      tick();
      check("e_out_valid", 32'(out_valid), 32'h0);
      check("e_busy", 32'(busy), 32'h0);
      check("e_cnt", 32'(dispatch_cnt), 32'd3);
      child_en = 5'b00001;
      #1;
      check("e_in_ready_en", 32'(in_ready), 32'h1);
      tick();
      check("e_out_valid_en", 32'(out_valid), 32'h01);
      check("e_out_data_en", 32'(out_data), 32'h0C01);
      in_valid = 1'b0;
      tick();
      check("e_cnt_after", 32'(dispatch_cnt), 32'd4);

      // Counter wrap from 0xFFFF.
      child_en = 5'b11111;
      force dut.r_cnt = 16'hFFFF;
      #1;
      release dut.r_cnt;
      #1;
      check("f_cnt_preload", 32'(dispatch_cnt), 32'hFFFF);
      in_valid = 1'b1;
      in_data  = 16'h0D01;
      tick();
      in_valid = 1'b0;
      check("f_out_valid", 32'(out_valid), 32'h02);
      tick();
      check("f_cnt_wrap", 32'(dispatch_cnt), 32'h0000);

      // Reset while FULL discards the word and restarts at child 0.
      out_ready = 5'b00000;
      in_valid  = 1'b1;
      in_data   = 16'h0E01;
      tick();
      in_valid = 1'b0;
      check("g_out_valid_full", 32'(out_valid), 32'h04);
      check("g_busy_full", 32'(busy), 32'h1);
      rst = 1'b1;
      #1;
      check("g_out_valid_rst", 32'(out_valid), 32'h0);
      check("g_busy_rst", 32'(busy), 32'h0);
      check("g_in_ready_rst", 32'(in_ready), 32'h0);
      tick();
      check("g_cnt_rst", 32'(dispatch_cnt), 32'h0);
      rst       = 1'b0;
      out_ready = 5'b11111;
      in_valid  = 1'b1;
      in_data   = 16'h0E02;
      #1;
      check("g_in_ready_rel", 32'(in_ready), 32'h1);
      tick();
      check("g_out_valid_rel", 32'(out_valid), 32'h01);
      check("g_out_data_rel", 32'(out_data), 32'h0E02);
      in_valid = 1'b0;
      tick();
      check("g_cnt_rel", 32'(dispatch_cnt), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
